// File: rtl/fmap_mem_responder_if.sv
// Purpose: word-access bus between a layer data loader (master) and the feature-map memory (slave).
// Latency: none; wiring only.
// Backpressure: valid is held by the master until the slave pulses the matching ready.
// Signals: rvalid/raddr -> rready/rdata for reads; wvalid/waddr/wdata -> wready for writes.
interface fmap_mem_responder_if;
    logic        rvalid;
    logic [25:0] raddr;
    logic        rready;
    logic [31:0] rdata;
    logic        wvalid;
    logic [25:0] waddr;
    logic [31:0] wdata;
    logic        wready;

    modport master (
        output rvalid, raddr, wvalid, waddr, wdata,
        input  rready, rdata, wready
    );

    modport slave (
        input  rvalid, raddr, wvalid, waddr, wdata,
        output rready, rdata, wready
    );
endinterface

// File: rtl/fmap_mem_responder.sv
// Purpose: single-port DEPTH x 32 feature-map memory answering one loader read or write at a time.
// Latency: ready pulses RD_LAT / WR_LAT cycles after acceptance; next acceptance no earlier than 2 cycles later.
// Backpressure: one access in flight; further valids wait (held by the initiator) until the FSM is idle again.
// Ports: clk, rst (sync, active-high); bus (slave side of fmap_mem_responder_if);
//        oob (sticky out-of-range completion), rd_cnt / wr_cnt (completed access counters, wrapping).
module fmap_mem_responder #(
    parameter int DEPTH_BITS = 16,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fmap_mem_responder_if.slave  bus,
    output logic                 oob,
    output logic [31:0]          rd_cnt,
    output logic [31:0]          wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP,
        S_GAP
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        op_wr;       // type of the access in flight
    logic        last_wr;     // last grant was a write; breaks read/write ties
    logic [25:0] addr_q;
    logic [31:0] data_q;

    logic        acc;         // a request is accepted this cycle
    logic        acc_wr;      // ... and it is a write
    logic [25:0] acc_addr;
    logic        resp_wr;     // type of the access about to enter S_RESP
    logic [25:0] resp_addr;
    logic        resp_oob;
    logic        enter_resp;

    function automatic logic addr_oob(input logic [25:0] a);
        return (a >> DEPTH_BITS) != 26'd0;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc       = 1'b0;
        acc_wr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.rvalid && bus.wvalid) begin
                    acc    = 1'b1;
                    acc_wr = !last_wr;
                end else if (bus.rvalid) begin
                    acc    = 1'b1;
                    acc_wr = 1'b0;
                end else if (bus.wvalid) begin
                    acc    = 1'b1;
                    acc_wr = 1'b1;
                end
                if (acc) begin
                    cnt_nxt = acc_wr ? WR_LOAD : RD_LOAD;
                    // A latency of 1 skips the counting state entirely.
                    if (cnt_nxt == 4'd0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = acc_wr ? S_WR : S_RD;
                    end
                end
            end
            S_RD, S_WR: begin
                if (cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_GAP;
            // Initiator's valid is still up for one cycle after ready; ignore it here.
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so everything visible in S_RESP is computed on the edge entering it.
    // With latency 1 that edge is the acceptance edge, so address/type come straight from the bus.
    assign acc_addr   = acc_wr ? bus.waddr : bus.raddr;
    assign resp_wr    = (state == S_IDLE) ? acc_wr : op_wr;
    assign resp_addr  = (state == S_IDLE) ? acc_addr : addr_q;
    assign resp_oob   = addr_oob(resp_addr);
    assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            op_wr      <= 1'b0;
            last_wr    <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            bus.rready <= 1'b0;
            bus.wready <= 1'b0;
            bus.rdata  <= '0;
            oob        <= 1'b0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bus.rready <= enter_resp && !resp_wr;
            bus.wready <= enter_resp && resp_wr;
            if (acc) begin
                op_wr   <= acc_wr;
                last_wr <= acc_wr;
                addr_q  <= acc_addr;
                if (acc_wr) begin
                    data_q <= bus.wdata;
                end
            end
            if (enter_resp) begin
                if (resp_oob) begin
                    oob <= 1'b1;
                end
                if (resp_wr) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end else begin
                    rd_cnt    <= rd_cnt + 32'd1;
                    bus.rdata <= resp_oob ? 32'h0 : mem[resp_addr[DEPTH_BITS-1:0]];
                end
            end
        end
    end

    // Commit at the edge ending S_RESP; a reset on that edge abandons the write.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RESP && op_wr && !addr_oob(addr_q)) begin
            mem[addr_q[DEPTH_BITS-1:0]] <= data_q;
        end
    end

endmodule
